// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Iterative multiply/divide unit owning the HI/LO register pair.
//            One multiplier/quotient bit per cycle, start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CALC = 2'd1;
    localparam logic [1:0] c_S_FIX  = 2'd2;

    localparam logic [5:0] c_OP_MULT  = 6'b011000;
    localparam logic [5:0] c_OP_MULTU = 6'b011001;
    localparam logic [5:0] c_OP_DIV   = 6'b011010;
    localparam logic [5:0] c_OP_DIVU  = 6'b011011;
    localparam logic [5:0] c_OP_MTHI  = 6'b010001;
    localparam logic [5:0] c_OP_MTLO  = 6'b010011;

    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_hw;
    logic [WIDTH-1:0]     r_lw;
    logic [WIDTH-1:0]     r_opb;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_is_div;
    logic                 r_sa;
    logic                 r_sb;
    logic                 r_b_zero;
    logic                 r_done;
    logic                 r_dz;

    logic                 w_accept;
    logic                 w_is_md;
    logic                 w_is_mthi;
    logic                 w_is_mtlo;
    logic                 w_signed_op;
    logic                 w_div_op;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_madd;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;
    logic                 w_fix_wr;

    // Operation decode; kill in IDLE suppresses any start
    assign w_accept    = (r_state == c_S_IDLE) && start && !kill;
    assign w_is_md     = (op == c_OP_MULT) || (op == c_OP_MULTU) ||
                         (op == c_OP_DIV)  || (op == c_OP_DIVU);
    assign w_is_mthi   = (op == c_OP_MTHI);
    assign w_is_mtlo   = (op == c_OP_MTLO);
    assign w_signed_op = (op == c_OP_MULT) || (op == c_OP_DIV);
    assign w_div_op    = (op == c_OP_DIV)  || (op == c_OP_DIVU);
    assign w_abs_a     = (w_signed_op && a[WIDTH-1]) ? -a : a;
    assign w_abs_b     = (w_signed_op && b[WIDTH-1]) ? -b : b;

    // Shift-add step: r_hw is the running upper half, r_lw holds the multiplier
    assign w_add  = {1'b0, r_hw} + {1'b0, r_opb};
    assign w_madd = r_lw[0] ? w_add : {1'b0, r_hw};

    // Restoring step: remainder stays below the divisor, so WIDTH bits suffice
    assign w_shift = {r_hw, r_lw[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opb});
    assign w_diff  = w_shift[WIDTH-1:0] - r_opb;

    assign w_prod     = {r_hw, r_lw};
    assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
    assign w_quo_fix  = (r_sa ^ r_sb) ? -r_lw : r_lw;
    assign w_rem_fix  = r_sa ? -r_hw : r_hw;

    always_comb begin
        w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            if (r_b_zero) begin
                w_res_hi = r_a;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_rem_fix;
                w_res_lo = w_quo_fix;
            end
        end
    end

    assign w_fix_wr = (r_state == c_S_FIX) && !kill;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_accept && w_is_md) w_state_nxt = c_S_CALC;
            c_S_CALC: begin
                if (kill)                    w_state_nxt = c_S_IDLE;
                else if (r_cnt == c_CNT_ONE) w_state_nxt = c_S_FIX;
            end
            c_S_FIX:  w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_S_CALC) || (r_state == c_S_FIX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_hw     <= '0;
            r_lw     <= '0;
            r_opb    <= '0;
            r_a      <= '0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_b_zero <= 1'b0;
        end else if (w_accept && w_is_md) begin
            r_cnt    <= c_CNT_INIT;
            r_is_div <= w_div_op;
            r_sa     <= w_signed_op && a[WIDTH-1];
            r_sb     <= w_signed_op && b[WIDTH-1];
            r_b_zero <= (b == '0);
            r_a      <= a;
            r_hw     <= '0;
            r_lw     <= w_div_op ? w_abs_a : w_abs_b;
            r_opb    <= w_div_op ? w_abs_b : w_abs_a;
        end else if (r_state == c_S_CALC) begin
            r_cnt <= r_cnt - c_CNT_ONE;
            if (r_is_div) begin
                r_hw <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                r_lw <= {r_lw[WIDTH-2:0], w_ge};
            end else begin
                r_hw <= w_madd[WIDTH:1];
                r_lw <= {w_madd[0], r_lw[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= w_fix_wr || (w_accept && (w_is_mthi || w_is_mtlo));
            if (w_fix_wr) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
                r_dz <= r_is_div && r_b_zero;
            end else if (busy && kill) begin
                r_dz <= 1'b0;
            end else if (w_accept && (w_is_md || w_is_mthi || w_is_mtlo)) begin
                r_dz <= 1'b0;
                if (w_is_mthi) r_hi <= a;
                if (w_is_mtlo) r_lo <= a;
            end
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign dz   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Directed bench for muldiv_seq with a result scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    localparam logic [5:0] c_MULT  = 6'b011000;
    localparam logic [5:0] c_MULTU = 6'b011001;
    localparam logic [5:0] c_DIV   = 6'b011010;
    localparam logic [5:0] c_DIVU  = 6'b011011;
    localparam logic [5:0] c_MTHI  = 6'b010001;
    localparam logic [5:0] c_MTLO  = 6'b010011;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [5:0]  op;
    logic [31:0] a, b;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi   = '0;
    logic [31:0] exp_lo   = '0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .kill(kill), .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic done in 64 bits so the most-negative/-1 case cannot overflow
    function automatic exp_t model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic signed [63:0] sx, sy, p, q, r;
        logic [63:0] up;
        e.hi = exp_hi;
        e.lo = exp_lo;
        e.dz = 1'b0;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            c_MULT: begin
                p = sx * sy;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            c_MULTU: begin
                up = {32'b0, x} * {32'b0, y};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            default: begin
                if (y == 32'h0) begin
                    e.hi = x;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else begin
                    if (o == c_DIV) begin
                        q = sx / sy;
                        r = sx % sy;
                    end else begin
                        q = {32'b0, x} / {32'b0, y};
                        r = {32'b0, x} % {32'b0, y};
                    end
                    e.hi = r[31:0];
                    e.lo = q[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Issues one mult/div, optionally pokes a start mid-flight, then checks the result
    task automatic do_op(input string tag, input logic [5:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int poke);
        exp_t e;
        int   cyc;
        sb_q.push_back(model(o, x, y));
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 1;
        chk({tag, "/done_low"}, done, 0);
        chk({tag, "/dz_clear"}, dz, 0);
        while (!done && cyc < 100) begin
            chk({tag, "/busy"}, busy, 1);
            if (cyc == poke) begin
                start = 1'b1; op = c_MULT; a = 32'd3; b = 32'd4;
            end else if (cyc == poke + 1) begin
                start = 1'b0; op = o;
            end
            tick();
            cyc++;
        end
        chk({tag, "/latency"}, cyc, 34);
        chk({tag, "/done"}, done, 1);
        chk({tag, "/busy_end"}, busy, 0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "/hi"}, hi, e.hi);
            chk({tag, "/lo"}, lo, e.lo);
            chk({tag, "/dz"}, dz, e.dz);
            exp_hi = e.hi;
            exp_lo = e.lo;
        end
    endtask

    task automatic do_mt(input string tag, input logic [5:0] o, input logic [31:0] x);
        exp_t e;
        e.hi = (o == c_MTHI) ? x : exp_hi;
        e.lo = (o == c_MTLO) ? x : exp_lo;
        e.dz = 1'b0;
        sb_q.push_back(e);
        op = o; a = x; start = 1'b1;
        tick();
        start = 1'b0; a = $urandom;
        chk({tag, "/done"}, done, 1);
        chk({tag, "/busy"}, busy, 0);
        e = sb_q.pop_front();
        chk({tag, "/hi"}, hi, e.hi);
        chk({tag, "/lo"}, lo, e.lo);
        exp_hi = e.hi;
        exp_lo = e.lo;
        tick();
        chk({tag, "/done_pulse"}, done, 0);
        chk({tag, "/busy_after"}, busy, 0);
    endtask

    // Starts a mult, then aborts it at cycle 10 with kill or rst
    task automatic abort_op(input string tag, input bit use_rst);
        int pulses;
        op = c_MULT; a = 32'd7; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        chk({tag, "/busy_c10"}, busy, 1);
        if (use_rst) rst = 1'b1; else kill = 1'b1;
        tick();
        rst = 1'b0; kill = 1'b0;
        if (use_rst) begin
            exp_hi = '0;
            exp_lo = '0;
        end
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/done"}, done, 0);
        chk({tag, "/dz"}, dz, 0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) pulses++;
            tick();
        end
        chk({tag, "/no_done"}, pulses, 0);
        chk({tag, "/hi"}, hi, exp_hi);
        chk({tag, "/lo"}, lo, exp_lo);
    endtask

    initial begin
        logic [5:0] ops [4];
        ops = '{c_MULT, c_MULTU, c_DIV, c_DIVU};
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset/busy", busy, 0);
        chk("reset/done", done, 0);
        chk("reset/dz", dz, 0);
        chk("reset/hi", hi, 0);
        chk("reset/lo", lo, 0);

        do_op("mult_neg", c_MULT, 32'hFFFF_FFFB, 32'h0000_0003, -1);
        do_op("multu_max", c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        do_op("multu_b2b", c_MULTU, 32'h0000_0002, 32'h0000_0003, -1);
        do_op("div_neg", c_DIV, 32'hFFFF_FFF9, 32'h0000_0002, -1);
        do_op("divu", c_DIVU, 32'h0000_0007, 32'h0000_0002, -1);
        do_op("divu_zero", c_DIVU, 32'h1234_5678, 32'h0000_0000, -1);
        tick();
        tick();
        chk("dz_hold/dz", dz, 1);
        chk("dz_hold/done", done, 0);
        do_op("div_ovf", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);

        do_mt("mthi", c_MTHI, 32'hAAAA_5555);
        do_mt("mtlo", c_MTLO, 32'h0000_BEEF);

        do_op("div_poke", c_DIV, 32'hFFFF_0000, 32'h0000_0123, 5);

        for (int i = 0; i < 4; i++)
            do_op("rand", ops[i], $urandom, $urandom_range(1, 5000), -1);

        op = 6'b100000; a = 32'h1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("bad_op/done", done, 0);
        chk("bad_op/busy", busy, 0);
        chk("bad_op/hi", hi, exp_hi);

        op = c_MTHI; a = 32'h5; start = 1'b1; kill = 1'b1;
        tick();
        start = 1'b0; kill = 1'b0;
        chk("kill_idle/done", done, 0);
        chk("kill_idle/hi", hi, exp_hi);

        abort_op("kill", 1'b0);
        abort_op("rst", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised, multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Successor to the single-cycle combinational arithmetic path: operand width is a parameter, and mult/div run iteratively, one bit per cycle.
- The datapath uses a start/busy/done handshake and supports a kill for exceptions and pipeline flushes.
- Sits beside the ALU in the EX stage; mfhi/mflo read the hi/lo outputs directly.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits; legal values are even numbers >= 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  6  operation code, using funct encoding: mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011.
- a  in  WIDTH  operand A (multiplicand, dividend, or mthi/mtlo source).
- b  in  WIDTH  operand B (multiplier or divisor).
- kill  in  1  abort the in-flight operation.
- busy  out  1  high while in CALC or FIX.
- done  out  1  one-cycle pulse when hi/lo have been updated.
- hi  out  WIDTH  HI register (product upper half, or remainder).
- lo  out  WIDTH  LO register (product lower half, or quotient).
- dz  out  1  divide by zero; valid with done, held until the next start.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, dz=0, hi=0, lo=0; counter and internal registers cleared. Reset has priority over everything, including mid-operation: the op is lost and hi/lo go to 0.
- States: IDLE, CALC, FIX.
- IDLE, start=1, op in {mult, multu, div, divu}:
  - latch |a|, |b| for signed ops (operands as-is for unsigned ops) and the sign flags;
  - counter=WIDTH; go to CALC.
- IDLE, start=1, op=mthi: hi<=a on that edge; lo unchanged; done=1 next cycle; no busy; stay in IDLE.
- IDLE, start=1, op=mtlo: same as mthi, but writes lo.
- IDLE, start=1, any other op: ignored; no done, no state change.
- CALC:
  - mult/multu: shift-add, one multiplier bit per cycle.
  - div/divu: restoring division, one quotient bit per cycle.
  - counter decrements each cycle; on reaching 1, go to FIX.
  - CALC lasts exactly WIDTH cycles.
- FIX:
  - apply two's-complement sign correction;
  - on the FIX->IDLE edge, write hi/lo and set done=1 for exactly one cycle.
- Latency: start sampled at edge 0 -> done high in cycle WIDTH+2, i.e. 34 cycles for WIDTH=32. hi/lo are valid in the same cycle done is high. A new start is accepted in that done cycle.
- start while busy=1: ignored, not queued.
- kill=1 in CALC or FIX: go to IDLE next edge; hi/lo unchanged; no done; dz=0.
- kill in IDLE: no effect. If kill and start are both 1 in IDLE, kill wins and the start is dropped.
- Signed mult: full 2*WIDTH product; hi = upper half, lo = lower half.
- Signed div: truncating division.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - lo = quotient, hi = remainder.
- Divide by zero (div or divu, b=0):
  - still takes full latency;
  - lo = all ones, hi = a unmodified;
  - dz = 1 with done.
- Signed overflow (div, a = most negative, b = -1): lo = a, hi = 0, dz = 0.
- Operands a/b are sampled only at the accepting edge; later changes have no effect on the op.
- hi/lo never change except on a done edge, an mthi/mtlo edge, or reset.

Test Plan:
- WIDTH=32. mult a=FFFFFFFB (-5), b=00000003 -> done in cycle 34, hi=FFFFFFFF, lo=FFFFFFF1, busy high for cycles 1..33.
- multu a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Back-to-back: multu 2*3 issued in the done cycle -> hi=0, lo=6, 34 cycles later.
- div a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. divu a=00000007, b=00000002 -> lo=3, hi=1.
- divu a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678, dz=1. div a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, dz=0.
- mthi a=AAAA5555 then mtlo a=0000BEEF -> hi=AAAA5555, lo=0000BEEF, one done pulse each, busy never high. start(mult) at cycle 5 of a running div -> ignored; div result correct.
- mult in flight, kill at cycle 10 -> IDLE next cycle, no done, hi/lo keep prior values. Repeat with rst at cycle 10 -> hi=lo=0, busy=0.
